// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu/ layer: FP32 field layout, canonical NaN,
// NaN test and the maxpool-forward state encoding.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [FP_W-1:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    MP_WAIT,
    MP_RD0,
    MP_RD1,
    MP_RD2,
    MP_RD3,
    MP_WR,
    MP_DONE
  } mp_state_t;

  // NaN: all-ones exponent with a non-zero mantissa (infinities excluded)
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (&x[FP_W-2 -: FP_EXP_W]) && (|x[FP_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fp_max32.sv
// Combinational IEEE-754 binary32 max. Any NaN input yields the canonical
// quiet NaN, so folding a window through it keeps a NaN sticky.
module fp_max32
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] y
);

  logic sa, sb;
  logic [FP_W-2:0] ma, mb;

  assign sa = a[FP_W-1];
  assign sb = b[FP_W-1];
  assign ma = a[FP_W-2:0];
  assign mb = b[FP_W-2:0];

  // Sign-magnitude ordering; +0 vs -0 falls out of the mixed-sign case.
  always_comb begin
    y = a;
    if (fp_is_nan(a) || fp_is_nan(b)) begin
      y = FP_CANON_NAN;
    end else if (sa != sb) begin
      y = sa ? b : a;
    end else if (!sa) begin
      y = (ma >= mb) ? a : b;
    end else begin
      y = (ma <= mb) ? a : b;
    end
  end

endmodule

// File: rtl/maxpool2x2_forward.sv
// 2x2 stride-2 max pool over a row-major FP32 map held in word-addressed
// memory. One output per RD0..RD3,WR sweep; row offsets are accumulated in
// a running row-base register rather than multiplied.
module maxpool2x2_forward
  import fpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              go,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  width,
  output logic              done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  mp_state_t state, state_nx;

  logic [DIM_W-1:0]  oh, ow, w_q;     // captured output dims and input width
  logic [DIM_W-1:0]  i, j;            // current output row / column
  logic [ADDR_W-1:0] row_base;        // src_base + 2*i*W
  logic [ADDR_W-1:0] out_addr;        // dst_base + i*OW + j
  logic [31:0]       mx, mx_fold;

  logic [ADDR_W-1:0] col_off, w_ext;
  logic              last_col, last_out, empty_req;

  assign col_off   = ADDR_W'(j) << 1;
  assign w_ext     = ADDR_W'(w_q);
  assign last_col  = (j == ow - DIM_W'(1));
  assign last_out  = last_col && (i == oh - DIM_W'(1));
  // H>>1 or W>>1 is zero exactly when the operand is below 2
  assign empty_req = (height < DIM_W'(2)) || (width < DIM_W'(2));

  fp_max32 u_max (
    .a (mx),
    .b (mem_rdata),
    .y (mx_fold)
  );

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= MP_WAIT;
    else        state <= state_nx;
  end

  // Next-state: each read/write state advances on its ack
  always_comb begin
    state_nx = state;
    case (state)
      MP_WAIT: if (go)      state_nx = empty_req ? MP_DONE : MP_RD0;
      MP_RD0:  if (mem_ack) state_nx = MP_RD1;
      MP_RD1:  if (mem_ack) state_nx = MP_RD2;
      MP_RD2:  if (mem_ack) state_nx = MP_RD3;
      MP_RD3:  if (mem_ack) state_nx = MP_WR;
      MP_WR:   if (mem_ack) state_nx = last_out ? MP_DONE : MP_RD0;
      MP_DONE: if (!go)     state_nx = MP_WAIT;
      default:              state_nx = MP_WAIT;
    endcase
  end

  // Memory-side outputs decoded from state; the registers feeding the
  // address and data only move on ack, so they hold while a request waits.
  always_comb begin
    done      = 1'b0;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      MP_RD0: begin
        busy = 1'b1; mem_req = 1'b1;
        mem_addr = row_base + col_off;
      end
      MP_RD1: begin
        busy = 1'b1; mem_req = 1'b1;
        mem_addr = row_base + col_off + ADDR_W'(1);
      end
      MP_RD2: begin
        busy = 1'b1; mem_req = 1'b1;
        mem_addr = row_base + w_ext + col_off;
      end
      MP_RD3: begin
        busy = 1'b1; mem_req = 1'b1;
        mem_addr = row_base + w_ext + col_off + ADDR_W'(1);
      end
      MP_WR: begin
        busy = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
        mem_addr  = out_addr;
        mem_wdata = mx;
      end
      MP_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, window accumulation and output-index walk
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      oh       <= '0;
      ow       <= '0;
      w_q      <= '0;
      i        <= '0;
      j        <= '0;
      row_base <= '0;
      out_addr <= '0;
      mx       <= '0;
    end else begin
      case (state)
        MP_WAIT: begin
          if (go) begin
            oh       <= height >> 1;
            ow       <= width >> 1;
            w_q      <= width;
            i        <= '0;
            j        <= '0;
            row_base <= src_base;
            out_addr <= dst_base;
          end
        end
        MP_RD0: if (mem_ack) mx <= mem_rdata;
        MP_RD1, MP_RD2, MP_RD3: if (mem_ack) mx <= mx_fold;
        MP_WR: begin
          if (mem_ack) begin
            out_addr <= out_addr + ADDR_W'(1);
            if (last_col) begin
              j        <= '0;
              i        <= i + DIM_W'(1);
              row_base <= row_base + (w_ext << 1);
            end else begin
              j <= j + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
